// File: rtl/sram_seq_pkg.sv
// rtl/sram_seq_pkg.sv - register map, bit positions and FSM states for the SRAM test sequencer
package sram_seq_pkg;

    localparam logic [2:0] REG_STA_ADDR  = 3'd0;
    localparam logic [2:0] REG_AREA_CFG  = 3'd1;
    localparam logic [2:0] REG_OP_CFG    = 3'd2;
    localparam logic [2:0] REG_SEND      = 3'd3;
    localparam logic [2:0] REG_ENABLE    = 3'd4;
    localparam logic [2:0] REG_OUTP_ADDR = 3'd5;
    localparam logic [2:0] REG_OUTP_DATA = 3'd6;
    localparam logic [2:0] REG_STATUS    = 3'd7;

    localparam int OP_WRITE_BIT        = 0;
    localparam int OP_PATTERN_LSB      = 8;
    localparam int STATUS_BUSY_BIT     = 0;
    localparam int STATUS_DONE_BIT     = 1;
    localparam int STATUS_MISMATCH_BIT = 2;

    localparam logic [10:0] MAX_LEN = 11'd1024;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_ADDR,
        S_W_AREA,
        S_W_OP,
        S_W_EN,
        S_SEND_SET,
        S_SEND_CLR,
        S_SETTLE,
        S_POLL,
        S_R_FA,
        S_R_FD,
        S_FIN,
        S_ABORT,
        S_REJECT
    } seq_state_t;

endpackage

// File: rtl/sram_avm_master.sv
// rtl/sram_avm_master.sv - single-cycle Avalon-MM access driver; bus idles to all zeros
module sram_avm_master
    import sram_seq_pkg::*;
(
    input  logic        req,
    input  logic        wr,
    input  logic [2:0]  idx,
    input  logic [31:0] wdata,
    output logic        avm_chipselect,
    output logic [2:0]  avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic [31:0] rdata,
    output logic        ack
);

    // The slave has no waitrequest, so every request completes in its own cycle.
    always_comb begin
        avm_chipselect = 1'b0;
        avm_address    = '0;
        avm_write      = 1'b0;
        avm_read       = 1'b0;
        avm_writedata  = '0;
        rdata          = '0;
        ack            = 1'b0;
        if (req) begin
            avm_chipselect = 1'b1;
            avm_address    = idx;
            avm_write      = wr;
            avm_read       = ~wr;
            avm_writedata  = wr ? wdata : 32'd0;
            rdata          = wr ? 32'd0 : avm_readdata;
            ack            = 1'b1;
        end
    end

endmodule

// File: rtl/sram_test_sequencer.sv
// rtl/sram_test_sequencer.sv - autonomous SRAM write/readback test master for the 8-register controller
module sram_test_sequencer
    import sram_seq_pkg::*;
#(
    parameter int POLL_TIMEOUT = 65535,
    parameter int SETTLE_CYC   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [9:0]  cfg_sta_addr,
    input  logic [10:0] cfg_len,
    input  logic [7:0]  cfg_pattern,
    output logic        avm_chipselect,
    output logic [2:0]  avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [9:0]  fail_addr,
    output logic [7:0]  fail_data,
    output logic        timeout
);

    localparam logic [16:0] SETTLE_LAST = 17'(SETTLE_CYC - 1);
    localparam logic [16:0] POLL_LAST   = 17'(POLL_TIMEOUT - 1);

    seq_state_t  state_q, state_d;
    logic [9:0]  sta_q, fa_q;
    logic [10:0] len_q;
    logic [7:0]  pat_q;
    logic        phase_q, mismatch_q;
    logic [16:0] cnt_q;

    logic        req, wr, ack;
    logic [2:0]  idx;
    logic [31:0] wdata, rdata;

    sram_avm_master u_master (
        .req            (req),
        .wr             (wr),
        .idx            (idx),
        .wdata          (wdata),
        .avm_chipselect (avm_chipselect),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_read       (avm_read),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .rdata          (rdata),
        .ack            (ack)
    );

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        wr      = 1'b0;
        idx     = '0;
        wdata   = '0;
        case (state_q)
            S_IDLE: if (start) state_d = (cfg_len == 11'd0 || cfg_len > MAX_LEN) ? S_REJECT : S_W_ADDR;
            S_W_ADDR: begin
                req = 1'b1; wr = 1'b1; idx = REG_STA_ADDR; wdata = {22'd0, sta_q};
                state_d = S_W_AREA;
            end
            S_W_AREA: begin
                req = 1'b1; wr = 1'b1; idx = REG_AREA_CFG; wdata = {21'd0, len_q};
                state_d = S_W_OP;
            end
            S_W_OP: begin
                req = 1'b1; wr = 1'b1; idx = REG_OP_CFG;
                wdata[OP_PATTERN_LSB +: 8] = pat_q;
                wdata[OP_WRITE_BIT]        = ~phase_q;
                state_d = phase_q ? S_SEND_SET : S_W_EN;
            end
            S_W_EN: begin
                req = 1'b1; wr = 1'b1; idx = REG_ENABLE; wdata = 32'd1;
                state_d = S_SEND_SET;
            end
            S_SEND_SET: begin
                req = 1'b1; wr = 1'b1; idx = REG_SEND; wdata = 32'd1;
                state_d = S_SEND_CLR;
            end
            S_SEND_CLR: begin
                req = 1'b1; wr = 1'b1; idx = REG_SEND;
                state_d = (SETTLE_CYC == 0) ? S_POLL : S_SETTLE;
            end
            S_SETTLE: if (cnt_q >= SETTLE_LAST) state_d = S_POLL;
            S_POLL: begin
                req = 1'b1; idx = REG_STATUS;
                if (rdata[STATUS_DONE_BIT]) state_d = phase_q ? S_R_FA : S_W_OP;
                else if (cnt_q >= POLL_LAST) state_d = S_ABORT;
            end
            S_R_FA: begin
                req = 1'b1; idx = REG_OUTP_ADDR;
                state_d = S_R_FD;
            end
            S_R_FD: begin
                req = 1'b1; idx = REG_OUTP_DATA;
                state_d = S_FIN;
            end
            S_FIN, S_ABORT: begin
                req = 1'b1; wr = 1'b1; idx = REG_ENABLE;
                state_d = S_IDLE;
            end
            S_REJECT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            sta_q      <= '0;
            len_q      <= '0;
            pat_q      <= '0;
            phase_q    <= 1'b0;
            mismatch_q <= 1'b0;
            cnt_q      <= '0;
            fa_q       <= '0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (start) begin
                    sta_q   <= cfg_sta_addr;
                    len_q   <= cfg_len;
                    pat_q   <= cfg_pattern;
                    phase_q <= 1'b0;
                    pass    <= 1'b0;
                    timeout <= 1'b0;
                end
                S_SEND_CLR: cnt_q <= '0;
                S_SETTLE:   cnt_q <= (state_d == S_POLL) ? 17'd0 : cnt_q + 17'd1;
                S_POLL: begin
                    mismatch_q <= rdata[STATUS_MISMATCH_BIT];
                    if (cnt_q != 17'h1ffff) cnt_q <= cnt_q + 17'd1;
                    if (state_d == S_W_OP) phase_q <= 1'b1;
                    if (state_d == S_ABORT) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                S_R_FA: if (ack) fa_q <= rdata[9:0];
                // Results become visible in the FIN cycle, alongside done.
                S_R_FD: begin
                    pass <= ~mismatch_q;
                    if (mismatch_q && ack) begin
                        fail_addr <= fa_q;
                        fail_data <= rdata[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_FIN) || (state_q == S_ABORT) || (state_q == S_REJECT);

    wire unused_rdata = ^rdata[31:10];

endmodule

// File: tb/tb_sram_test_sequencer.sv
// tb/tb_sram_test_sequencer.sv - scoreboard bench for sram_test_sequencer with a behavioural slave
module tb_sram_test_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  cfg_sta_addr = '0;
    logic [10:0] cfg_len = '0;
    logic [7:0]  cfg_pattern = '0;
    logic        avm_chipselect, avm_write, avm_read;
    logic [2:0]  avm_address;
    logic [31:0] avm_writedata, avm_readdata;
    logic        busy, done, pass, timeout;
    logic [9:0]  fail_addr;
    logic [7:0]  fail_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_test_sequencer #(.POLL_TIMEOUT(8), .SETTLE_CYC(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .cfg_sta_addr   (cfg_sta_addr),
        .cfg_len        (cfg_len),
        .cfg_pattern    (cfg_pattern),
        .avm_chipselect (avm_chipselect),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_read       (avm_read),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_addr      (fail_addr),
        .fail_data      (fail_data),
        .timeout        (timeout)
    );

    // Behavioural slave: status done appears slv_delay cycles after send is set.
    int         slv_delay = 1;
    logic       slv_never = 1'b0;
    logic       slv_mis = 1'b0;
    logic [9:0] slv_fa = '0;
    logic [7:0] slv_fd = '0;
    int         since_send = 0;
    logic       slv_active = 1'b0;
    logic       slv_done;

    always @(posedge clk) begin
        if (avm_chipselect && avm_write && avm_address == 3'd3 && avm_writedata[0]) begin
            since_send <= 1;
            slv_active <= 1'b1;
        end else if (since_send < 1000) begin
            since_send <= since_send + 1;
        end
    end

    assign slv_done = slv_active && !slv_never && (since_send >= slv_delay);

    always_comb begin
        avm_readdata = '0;
        case (avm_address)
            3'd5: avm_readdata = {22'd0, slv_fa};
            3'd6: avm_readdata = {24'd0, slv_fd};
            3'd7: avm_readdata = {29'd0, slv_done & slv_mis, slv_done, slv_active & ~slv_done};
            default: avm_readdata = '0;
        endcase
    end

    typedef struct packed {
        logic        wr;
        logic [2:0]  adr;
        logic [31:0] data;
    } bus_t;

    typedef struct packed {
        logic       pass;
        logic       to;
        logic [9:0] fa;
        logic [7:0] fd;
    } res_t;

    bus_t bus_q[$];
    res_t res_q[$];

    always @(negedge clk) begin
        bus_t e;
        res_t r;
        checks++;
        if (avm_chipselect) begin
            if (bus_q.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected: got wr=%0b rd=%0b adr=%0d data=%h, required no access",
                         avm_write, avm_read, avm_address, avm_writedata);
            end else begin
                e = bus_q.pop_front();
                if ({avm_write, avm_read, avm_address, avm_writedata} != {e.wr, ~e.wr, e.adr, e.data}) begin
                    errors++;
                    $display("FAIL bus_access: got wr=%0b rd=%0b adr=%0d data=%h, required wr=%0b adr=%0d data=%h",
                             avm_write, avm_read, avm_address, avm_writedata, e.wr, e.adr, e.data);
                end
            end
        end else if ({avm_write, avm_read, avm_address, avm_writedata} != 37'd0) begin
            errors++;
            $display("FAIL bus_idle: got wr=%0b rd=%0b adr=%0d data=%h, required all zero",
                     avm_write, avm_read, avm_address, avm_writedata);
        end
        if (done) begin
            checks++;
            if (res_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: done high with no result expected");
            end else begin
                r = res_q.pop_front();
                if ({busy, pass, timeout, fail_addr, fail_data} != {1'b1, r.pass, r.to, r.fa, r.fd}) begin
                    errors++;
                    $display("FAIL result: got busy=%0b pass=%0b to=%0b fa=%h fd=%h, required busy=1 pass=%0b to=%0b fa=%h fd=%h",
                             busy, pass, timeout, fail_addr, fail_data, r.pass, r.to, r.fa, r.fd);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic pw(input logic [2:0] a, input logic [31:0] d);
        bus_q.push_back('{1'b1, a, d});
    endtask

    task automatic pr(input logic [2:0] a, input int n);
        for (int i = 0; i < n; i++) bus_q.push_back('{1'b0, a, 32'd0});
    endtask

    task automatic push_run(input logic [9:0] sta, input logic [10:0] len, input logic [7:0] pat,
                            input int n0, input int n1);
        pw(3'd0, {22'd0, sta});
        pw(3'd1, {21'd0, len});
        pw(3'd2, {16'd0, pat, 8'h01});
        pw(3'd4, 32'd1);
        pw(3'd3, 32'd1);
        pw(3'd3, 32'd0);
        pr(3'd7, n0);
        if (n1 > 0) begin
            pw(3'd2, {16'd0, pat, 8'h00});
            pw(3'd3, 32'd1);
            pw(3'd3, 32'd0);
            pr(3'd7, n1);
        end
    endtask

    task automatic push_tail();
        pr(3'd5, 1);
        pr(3'd6, 1);
        pw(3'd4, 32'd0);
    endtask

    task automatic kick(input logic [9:0] sta, input logic [10:0] len, input logic [7:0] pat);
        cfg_sta_addr = sta;
        cfg_len      = len;
        cfg_pattern  = pat;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    // Returns the number of cycles between the first busy cycle and the done cycle.
    task automatic wait_done(output int k_out);
        k_out = -1;
        for (int k = 0; k < 400; k++) begin
            if (done) begin
                k_out = k;
                break;
            end
            @(negedge clk);
        end
        if (k_out < 0) begin
            errors++;
            checks++;
            $display("FAIL done_wait: got no done within 400 cycles, required a done pulse");
        end
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge clk);
        chk({name, "_bus_q"}, 64'(bus_q.size()), 64'd0);
        chk({name, "_res_q"}, 64'(res_q.size()), 64'd0);
    endtask

    initial begin
        int  lat;
        bit  ph1;
        bit  hit;

        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy, done, pass, timeout, fail_addr, fail_data, avm_chipselect}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: clean pass, done 5 cycles after send, two polls per phase
        slv_delay = 5; slv_never = 1'b0; slv_mis = 1'b0;
        push_run(10'h010, 11'd4, 8'hA5, 2, 2);
        push_tail();
        res_q.push_back('{1'b1, 1'b0, 10'h000, 8'h00});
        kick(10'h010, 11'd4, 8'hA5);
        wait_done(lat);
        drain("t1");
        chk("t1_pass_held", pass, 1);

        // 2: mismatch reported, minimum latency
        slv_delay = 1; slv_mis = 1'b1; slv_fa = 10'h013; slv_fd = 8'h5A;
        push_run(10'h020, 11'd16, 8'h3C, 1, 1);
        push_tail();
        res_q.push_back('{1'b0, 1'b0, 10'h013, 8'h5A});
        kick(10'h020, 11'd16, 8'h3C);
        wait_done(lat);
        chk("t2_latency", 64'(lat), 64'd17);
        drain("t2");

        // 3: slave never done, abort after 8 polls in phase 0
        slv_never = 1'b1; slv_mis = 1'b0;
        push_run(10'h100, 11'd8, 8'hFF, 8, 0);
        pw(3'd4, 32'd0);
        res_q.push_back('{1'b0, 1'b1, 10'h013, 8'h5A});
        kick(10'h100, 11'd8, 8'hFF);
        wait_done(lat);
        chk("t3_latency", 64'(lat), 64'd16);
        drain("t3");
        chk("t3_timeout_held", timeout, 1);

        // 4: out-of-range lengths are rejected without bus traffic
        slv_never = 1'b0;
        res_q.push_back('{1'b0, 1'b0, 10'h013, 8'h5A});
        kick(10'h001, 11'd0, 8'h11);
        wait_done(lat);
        chk("t4_len0_latency", 64'(lat), 64'd0);
        drain("t4a");
        res_q.push_back('{1'b0, 1'b0, 10'h013, 8'h5A});
        kick(10'h001, 11'd1025, 8'h11);
        wait_done(lat);
        chk("t4_len1025_latency", 64'(lat), 64'd0);
        drain("t4b");

        // 5: reset during phase-1 polling, then a full rerun
        slv_delay = 5;
        push_run(10'h3FF, 11'd1, 8'h00, 2, 1);
        kick(10'h3FF, 11'd1, 8'h00);
        ph1 = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            if (avm_write && avm_address == 3'd2 && !avm_writedata[0]) ph1 = 1'b1;
            if (ph1 && avm_read && avm_address == 3'd7) hit = 1'b1;
            else @(negedge clk);
        end
        chk("t5_reached_phase1_poll", hit, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t5_reset_outputs", {busy, done, pass, timeout, fail_addr, fail_data, avm_chipselect,
                                 avm_read, avm_write, avm_address}, 64'd0);
        chk("t5_reset_wdata", avm_writedata, 64'd0);
        reset_n = 1'b1;
        drain("t5a");
        slv_delay = 1;
        push_run(10'h3FF, 11'd1, 8'h00, 1, 1);
        push_tail();
        res_q.push_back('{1'b1, 1'b0, 10'h000, 8'h00});
        kick(10'h3FF, 11'd1, 8'h00);
        wait_done(lat);
        chk("t5_rerun_latency", 64'(lat), 64'd17);
        drain("t5b");

        // 6: starts while busy and during done are ignored; len 1024 is accepted
        push_run(10'h155, 11'd1024, 8'h81, 1, 1);
        push_tail();
        res_q.push_back('{1'b1, 1'b0, 10'h000, 8'h00});
        kick(10'h155, 11'd1024, 8'h81);
        repeat (4) @(negedge clk);
        cfg_sta_addr = 10'h2AA;
        cfg_len      = 11'd7;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        wait_done(lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_idle_after", busy, 0);
        drain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_test_sequencer.md
Name: sram_test_sequencer

Overview:
Avalon-MM master that autonomously runs one SRAM write-then-readback test through the 8-register SRAM controller slave (avalon_wrapper register map). It programs start address, area and operation registers, pulses send, polls status, fetches the failure address/data registers and reports pass/fail. It sits directly upstream of the slave, in place of the Nios/host, for standalone board bring-up.

Parameters:
POLL_TIMEOUT, 65535, max poll reads per phase before abort
SETTLE_CYC, 2, idle cycles after send clear before first poll (covers the slave's registered status lag)

Ports:
clk  in  1  system clock, shared with the slave's avalon_clk
reset_n  in  1  synchronous active-low reset
start  in  1  1-cycle pulse; accepted only in IDLE
cfg_sta_addr  in  10  first SRAM address
cfg_len  in  11  word count, 1..1024
cfg_pattern  in  8  data byte written to every word
avm_chipselect  out  1  slave select
avm_address  out  3  register index 0..7
avm_write  out  1  write strobe
avm_read  out  1  read strobe
avm_writedata  out  32  write data
avm_readdata  in  32  read data, combinational, valid in the same cycle as avm_read
busy  out  1  test in progress
done  out  1  1-cycle pulse at end of test
pass  out  1  result of last test, held until next start
fail_addr  out  10  first failing address (slave reg5[9:0])
fail_data  out  8  data read at fail_addr (slave reg6[7:0])
timeout  out  1  last test aborted on poll timeout, held until next start

Behaviour:
- Reset (sync, reset_n low at a clk edge): all outputs 0, state IDLE, counters 0. Reset mid-test aborts immediately; no further bus cycles.
- Bus rule: the slave has no waitrequest, so every access is exactly one cycle, chipselect asserted with write or read, never both. Bus is idle (all strobes 0, address 0, writedata 0) between accesses.
- Slave register map: 0 sta_addr, 1 area_cfg (len), 2 op_cfg, 3 send, 4 enable, 5 outp_addr, 6 outp_data, 7 status. op_cfg[0] = 1 write / 0 read; op_cfg[15:8] = pattern. status[0] = busy, status[1] = done, status[2] = mismatch.
- start latches the cfg_* inputs. start is ignored while busy. cfg_len of 0 or above 1024 yields done plus pass=0 and no bus traffic.
- FSM, one state per cycle unless noted. The phase bit is 0 for write and 1 for read.
  - IDLE
  - W_ADDR: write reg0 with {22'b0, sta_addr}.
  - W_AREA: write reg1 with {21'b0, len}.
  - W_OP: write reg2 with {16'b0, pattern, 7'b0, ~phase}.
  - W_EN: write reg4 with 1. Issued in phase 0 only; phase 1 skips it.
  - SEND_SET: write reg3 with 1.
  - SEND_CLR: write reg3 with 0.
  - SETTLE: SETTLE_CYC idle cycles.
  - POLL: read reg7 each cycle.
    - If status[1]=1 and phase 0: set phase 1 and go to W_OP (the address and area registers are retained).
    - If status[1]=1 and phase 1: go to R_FA.
    - If the poll count reaches POLL_TIMEOUT: go to ABORT.
  - R_FA: read reg5 and latch the failure address.
  - R_FD: read reg6 and latch the failure data.
  - FIN:
    - pass = ~status[2], using the status word captured at the final poll.
    - fail_addr/fail_data are updated only when pass=0. Otherwise they keep their previous values.
    - done pulses for 1 cycle.
    - Write reg4 with 0, then return to IDLE.
  - ABORT: write reg4 with 0, set timeout=1, pass=0, pulse done, return to IDLE.
- busy=1 from the cycle after start is accepted until the cycle done pulses, inclusive. busy drops with done.
- The poll counter is 17 bits, resets per phase and saturates. It never wraps.
- Minimum latency from start to done with an immediately done slave is 17 cycles at SETTLE_CYC=2. The bench checks exact equality.

Decomposition:
- Package sram_seq_pkg holds the register index constants (REG_STA_ADDR..REG_STATUS), the op_cfg/status bit positions and the state enum.
- One sub-module, sram_avm_master: a single-access driver with inputs req, wr, idx, wdata; outputs strobes, rdata and ack in the same cycle. The FSM stays in the top.

Test Plan:
1. start, sta_addr=0x010, len=4, pattern=0xA5, slave model asserts done 5 cycles after send -> exact bus sequence: writes reg0=0x10, reg1=4, reg2=0xA501, reg4=1, reg3=1, reg3=0, polls, reg2=0xA500, ...; pass=1, done pulses once.
2. Slave reports mismatch, reg5=0x013, reg6=0x5A -> pass=0, fail_addr=0x013, fail_data=0x5A, final write reg4=0.
3. Slave never sets done, POLL_TIMEOUT=8 -> exactly 8 reads of reg7 in phase 0, then timeout=1, pass=0, done pulse, reg4=0 written.
4. len=0 -> done pulse 1 cycle after start, pass=0, no chipselect ever asserted.
5. reset_n low during POLL of phase 1 -> next edge: all outputs 0, bus idle. A subsequent start runs the full sequence again from W_ADDR.
6. start asserted while busy, and start together with done -> the extra start is ignored; cfg latched at the first start is unchanged (reg0 value checked).
